priv_hpm_counters: RTL and testbench

PRIV_HPM_COUNTERS -- requirements
Module: priv_hpm_counters

---
 rtl/priv_hpm_counters.sv | 82 ++++++++
 tb/tb_priv_hpm_counters.sv | 266 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/priv_hpm_counters.sv
// priv_hpm_counters: hardware performance counters FIRST_IDX..31 with a registered
// event stage, CSR half-word writes, sticky overflow flags and an overflow interrupt.
//   CLK, nRST            clock, synchronous active-low reset
//   hpm_inc, inhibit     per-index event pulses and mcountinhibit image
//   wr_en/idx/hi/data    CSR write of one 32-bit half of a counter
//   rd_idx, rd_lo/hi     combinational read of the selected counter
//   ovf_clr, ovf_int_en  sticky overflow clear and interrupt enable
//   ovf, ovf_int         sticky overflow flags and registered interrupt request
// CNT_W is expected to lie in 33..64.
module priv_hpm_counters #(
    parameter int CNT_W     = 64,
    parameter int FIRST_IDX = 3
) (
    input  logic        CLK,
    input  logic        nRST,
    input  logic [31:0] hpm_inc,
    input  logic [31:0] inhibit,
    input  logic        wr_en,
    input  logic [4:0]  wr_idx,
    input  logic        wr_hi,
    input  logic [31:0] wr_data,
    input  logic [4:0]  rd_idx,
    output logic [31:0] rd_lo,
    output logic [31:0] rd_hi,
    input  logic [31:0] ovf_clr,
    input  logic [31:0] ovf_int_en,
    output logic [31:0] ovf,
    output logic        ovf_int
);
    localparam logic [31:0] IMPL = 32'hFFFF_FFFF << FIRST_IDX;

    logic [31:0]      r_inc_q;
    logic [31:0]      r_ovf;
    logic             r_ovf_int;
    logic [31:0]      w_ovf_set;
    logic [CNT_W-1:0] w_cnt [32];

    for (genvar g = 0; g < 32; g++) begin : g_cnt
        if (g >= FIRST_IDX) begin : g_impl
            logic [CNT_W-1:0] r_cnt;
            logic             w_wr;
            logic             w_inc;
            assign w_wr  = wr_en && (wr_idx == 5'(g));
            // a write to this counter swallows its pending increment
            assign w_inc = r_inc_q[g] && !w_wr;
            assign w_ovf_set[g] = w_inc && (&r_cnt);
            assign w_cnt[g] = r_cnt;
            always_ff @(posedge CLK) begin
                if (!nRST)
                    r_cnt <= '0;
                else if (w_wr && wr_hi)
                    r_cnt[CNT_W-1:32] <= wr_data[CNT_W-33:0];
                else if (w_wr)
                    r_cnt[31:0] <= wr_data;
                else if (w_inc)
                    r_cnt <= r_cnt + CNT_W'(1);
            end
        end else begin : g_none
            assign w_cnt[g] = '0;
            // inc_q is masked for unimplemented indices, so this is always 0
            assign w_ovf_set[g] = r_inc_q[g];
        end
    end

    always_ff @(posedge CLK) begin
        if (!nRST) begin
            r_inc_q   <= '0;
            r_ovf     <= '0;
            r_ovf_int <= 1'b0;
        end else begin
            r_inc_q   <= hpm_inc & ~inhibit & IMPL;
            // set wins over a simultaneous clear
            r_ovf     <= (r_ovf & ~ovf_clr) | w_ovf_set;
            r_ovf_int <= |(r_ovf & ovf_int_en);
        end
    end

    assign rd_lo   = w_cnt[rd_idx][31:0];
    assign rd_hi   = 32'(w_cnt[rd_idx][CNT_W-1:32]);
    assign ovf     = r_ovf;
    assign ovf_int = r_ovf_int;
endmodule

// File: tb/tb_priv_hpm_counters.sv
// tb_priv_hpm_counters: directed and randomized checks of priv_hpm_counters
module tb_priv_hpm_counters;
    logic        CLK = 1'b0;
    logic        nRST;
    logic [31:0] hpm_inc, inhibit, wr_data, ovf_clr, ovf_int_en;
    logic        wr_en, wr_hi;
    logic [4:0]  wr_idx, rd_idx;
    logic [31:0] rd_lo, rd_hi, ovf;
    logic        ovf_int;

    int checks = 0;
    int errors = 0;

    logic [31:0] got_lo [32];
    logic [31:0] got_hi [32];

    logic [63:0] m_cnt [32];
    logic [31:0] m_pend, m_ovf;
    logic        m_int;

    priv_hpm_counters dut (
        .CLK(CLK), .nRST(nRST), .hpm_inc(hpm_inc), .inhibit(inhibit),
        .wr_en(wr_en), .wr_idx(wr_idx), .wr_hi(wr_hi), .wr_data(wr_data),
        .rd_idx(rd_idx), .rd_lo(rd_lo), .rd_hi(rd_hi),
        .ovf_clr(ovf_clr), .ovf_int_en(ovf_int_en), .ovf(ovf), .ovf_int(ovf_int)
    );

    always #50 CLK = ~CLK;

    // reference: counters are 64-bit integers, events become visible one cycle after sampling
    always @(posedge CLK) begin
        logic [63:0] nc [32];
        logic [31:0] set;
        nc  = m_cnt;
        set = '0;
        if (!nRST) begin
            for (int i = 0; i < 32; i++) nc[i] = '0;
            m_pend <= '0;
            m_ovf  <= '0;
            m_int  <= 1'b0;
        end else begin
            for (int i = 3; i < 32; i++) begin
                if (wr_en && wr_idx == 5'(i)) begin
                    if (wr_hi) nc[i][63:32] = wr_data;
                    else       nc[i][31:0]  = wr_data;
                end else if (m_pend[i]) begin
                    if (nc[i] == 64'hFFFF_FFFF_FFFF_FFFF) set[i] = 1'b1;
                    nc[i] = nc[i] + 64'd1;
                end
            end
            m_int  <= |(m_ovf & ovf_int_en);
            m_ovf  <= (m_ovf & ~ovf_clr) | set;
            m_pend <= hpm_inc & ~inhibit & 32'hFFFF_FFF8;
        end
        m_cnt <= nc;
    end

    task automatic step();
        @(posedge CLK);
        #1;
    endtask

    task automatic read_all();
        for (int i = 0; i < 32; i++) begin
            rd_idx = 5'(i);
            #1;
            got_lo[i] = rd_lo;
            got_hi[i] = rd_hi;
        end
    endtask

    task automatic test_reset();
        nRST = 1'b0; hpm_inc = '1; inhibit = '0; wr_en = 1'b1; wr_idx = 5'd9; wr_hi = 1'b0;
        wr_data = 32'h1234; ovf_clr = '0; ovf_int_en = '1; rd_idx = '0;
        step(); step();
        wr_en = 1'b0; hpm_inc = '0;
        read_all();
        for (int i = 0; i < 32; i++) begin
            checks++;
            if (got_lo[i] !== 32'h0 || got_hi[i] !== 32'h0) begin
                errors++; $display("FAIL reset_cnt[%0d] got %h_%h exp 0", i, got_hi[i], got_lo[i]);
            end
        end
        checks++;
        if (ovf !== 32'h0 || ovf_int !== 1'b0) begin
            errors++; $display("FAIL reset_ovf got ovf=%h int=%b exp 0/0", ovf, ovf_int);
        end
        nRST = 1'b1; ovf_int_en = '0;
    endtask

    task automatic test_latency();
        logic [31:0] exp;
        hpm_inc = 32'h1 << 5;
        for (int k = 1; k <= 5; k++) begin
            step();
            if (k == 3) hpm_inc = '0;
            rd_idx = 5'd5;
            #1;
            exp = (k < 2) ? 32'd0 : (k - 1 > 3) ? 32'd3 : 32'(k - 1);
            checks++;
            if (rd_lo !== exp || rd_hi !== 32'h0) begin
                errors++; $display("FAIL latency k=%0d got %h_%h exp %0d", k, rd_hi, rd_lo, exp);
            end
        end
    endtask

    task automatic test_inhibit();
        inhibit = 32'h1 << 7; hpm_inc = 32'h1 << 7;
        repeat (4) step();
        inhibit = '0; hpm_inc = 32'h1 << 2;
        repeat (2) step();
        hpm_inc = '0;
        repeat (2) step();
        read_all();
        for (int i = 0; i < 32; i++) begin
            checks++;
            if (got_lo[i] !== ((i == 5) ? 32'd3 : 32'd0) || got_hi[i] !== 32'h0) begin
                errors++; $display("FAIL inhibit_cnt[%0d] got %h_%h exp %0d", i, got_hi[i], got_lo[i], (i == 5) ? 3 : 0);
            end
        end
        checks++;
        if (ovf !== 32'h0) begin
            errors++; $display("FAIL inhibit_ovf got %h exp 0", ovf);
        end
    endtask

    task automatic test_overflow();
        wr_en = 1'b1; wr_idx = 5'd4; wr_hi = 1'b1; wr_data = 32'hFFFF_FFFF;
        step();
        wr_hi = 1'b0;
        step();
        wr_en = 1'b0; rd_idx = 5'd4;
        #1;
        checks++;
        if (rd_lo !== 32'hFFFF_FFFF || rd_hi !== 32'hFFFF_FFFF || ovf !== 32'h0) begin
            errors++; $display("FAIL wr_load got %h_%h ovf=%h exp ffffffff_ffffffff ovf=0", rd_hi, rd_lo, ovf);
        end
        hpm_inc = 32'h1 << 4; ovf_int_en = 32'h1 << 4;
        step();
        hpm_inc = '0;
        step();
        rd_idx = 5'd4;
        #1;
        checks++;
        if (rd_lo !== 32'h0 || rd_hi !== 32'h0 || ovf !== 32'h10 || ovf_int !== 1'b0) begin
            errors++; $display("FAIL wrap got %h_%h ovf=%h int=%b exp 0_0 ovf=10 int=0", rd_hi, rd_lo, ovf, ovf_int);
        end
        step();
        checks++;
        if (ovf_int !== 1'b1) begin
            errors++; $display("FAIL ovf_int_rise got %b exp 1", ovf_int);
        end
        wr_en = 1'b1; wr_hi = 1'b1;
        step();
        wr_hi = 1'b0;
        step();
        wr_en = 1'b0; hpm_inc = 32'h1 << 4;
        step();
        hpm_inc = '0; ovf_clr = 32'h1 << 4;
        step();
        checks++;
        if (ovf !== 32'h10) begin
            errors++; $display("FAIL set_beats_clr got ovf=%h exp 10", ovf);
        end
        step();
        checks++;
        if (ovf !== 32'h0 || ovf_int !== 1'b1) begin
            errors++; $display("FAIL clr got ovf=%h int=%b exp 0/1", ovf, ovf_int);
        end
        ovf_clr = '0;
        step();
        checks++;
        if (ovf_int !== 1'b0) begin
            errors++; $display("FAIL ovf_int_fall got %b exp 0", ovf_int);
        end
    endtask

    task automatic test_write_priority();
        hpm_inc = (32'h1 << 5) | (32'h1 << 6);
        step();
        hpm_inc = '0; wr_en = 1'b1; wr_idx = 5'd6; wr_hi = 1'b0; wr_data = 32'h10;
        step();
        wr_idx = 5'd2; wr_data = 32'h55;
        step();
        wr_idx = 5'd9; wr_data = 32'h0;
        step();
        wr_en = 1'b0;
        read_all();
        for (int i = 0; i < 32; i++) begin
            checks++;
            if (got_lo[i] !== ((i == 5) ? 32'd4 : (i == 6) ? 32'h10 : 32'd0) || got_hi[i] !== 32'h0) begin
                errors++; $display("FAIL wr_prio_cnt[%0d] got %h_%h exp %0d", i, got_hi[i], got_lo[i], (i == 5) ? 4 : (i == 6) ? 16 : 0);
            end
        end
        checks++;
        if (ovf !== 32'h0) begin
            errors++; $display("FAIL wr_no_ovf got %h exp 0", ovf);
        end
    endtask

    task automatic test_mid_reset();
        hpm_inc = '1;
        step();
        nRST = 1'b0; wr_en = 1'b1; wr_idx = 5'd8; wr_hi = 1'b0; wr_data = 32'h77;
        step();
        wr_en = 1'b0; hpm_inc = '0;
        read_all();
        for (int i = 0; i < 32; i++) begin
            checks++;
            if (got_lo[i] !== 32'h0 || got_hi[i] !== 32'h0) begin
                errors++; $display("FAIL midrst_cnt[%0d] got %h_%h exp 0", i, got_hi[i], got_lo[i]);
            end
        end
        nRST = 1'b1;
        step(); step();
        read_all();
        for (int i = 0; i < 32; i++) begin
            checks++;
            if (got_lo[i] !== 32'h0 || got_hi[i] !== 32'h0) begin
                errors++; $display("FAIL late_inc[%0d] got %h_%h exp 0", i, got_hi[i], got_lo[i]);
            end
        end
        checks++;
        if (ovf !== 32'h0 || ovf_int !== 1'b0) begin
            errors++; $display("FAIL midrst_ovf got ovf=%h int=%b exp 0/0", ovf, ovf_int);
        end
    endtask

    task automatic test_random();
        for (int c = 0; c < 600; c++) begin
            nRST       = ($urandom_range(0, 99) != 0);
            hpm_inc    = $urandom;
            inhibit    = $urandom & $urandom & $urandom;
            wr_en      = ($urandom_range(0, 3) == 0);
            wr_idx     = 5'($urandom);
            wr_hi      = 1'($urandom);
            wr_data    = ($urandom_range(0, 1) == 1) ? 32'hFFFF_FFFF - $urandom_range(0, 3) : $urandom;
            ovf_clr    = $urandom & $urandom & $urandom;
            ovf_int_en = $urandom;
            step();
            read_all();
            for (int i = 0; i < 32; i++) begin
                checks++;
                if ({got_hi[i], got_lo[i]} !== m_cnt[i]) begin
                    errors++; $display("FAIL rand_cnt[%0d] c=%0d got %h_%h exp %h", i, c, got_hi[i], got_lo[i], m_cnt[i]);
                end
            end
            checks++;
            if (ovf !== m_ovf || ovf_int !== m_int) begin
                errors++; $display("FAIL rand_ovf c=%0d got ovf=%h int=%b exp ovf=%h int=%b", c, ovf, ovf_int, m_ovf, m_int);
            end
        end
    endtask

    initial begin
        test_reset();
        test_latency();
        test_inhibit();
        test_overflow();
        test_write_priority();
        test_mid_reset();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
